// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port P has fixed priority over auxiliary port A.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_rd,
    input  logic                  p_wr,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_func3,
    output logic                  p_stall,
    output logic                  p_rvalid,
    output logic [DATA_W-1:0]     p_rdata,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [DM_ADDRESS-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [2:0]            a_func3,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_func3,
    input  logic [DATA_W-1:0]     m_rdata
);
    // state | meaning
    // NORM  | P has priority; A issues only when P idle
    // FORCE | A starved STARVE_MAX cycles; A issues this cycle, P stalls if requesting

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("dmem_arbiter: STARVE_MAX must be in 1..255");
    end

    logic       p_req;
    logic       force_a;
    logic       p_issue;
    logic       a_issue;
    logic [1:0] rd_own;

    assign p_req = p_rd | p_wr;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        NORM  = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] starve_cnt;

    // A dropping its request before the forced slot leaves P unaffected.
    assign force_a = (state == FORCE) && a_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= NORM;
            starve_cnt <= 8'd0;
        end else begin
            case (state)
                NORM: begin
                    if (!a_req || a_issue) begin
                        starve_cnt <= 8'd0;
                    end else if (p_issue) begin
                        if (starve_cnt + 8'd1 == STARVE_LIM) begin
                            state      <= FORCE;
                            starve_cnt <= STARVE_LIM;
                        end else begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end
                end
                FORCE: begin
                    state      <= NORM;
                    starve_cnt <= 8'd0;
                end
                default: begin
                    state      <= NORM;
                    starve_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign p_stall = reset && p_req && force_a;
`else
    assign force_a = 1'b0;
    assign p_stall = 1'b0;
`endif

    always_comb begin
        p_issue = reset && p_req && !force_a;
        a_issue = reset && a_req && (force_a || !p_req);
    end

    assign a_gnt = a_issue;

    // Write wins when P asserts both read and write.
    always_comb begin
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_func3 = 3'd0;
        if (p_issue) begin
            m_wr    = p_wr;
            m_rd    = p_rd & ~p_wr;
            m_addr  = p_addr;
            m_wdata = p_wdata;
            m_func3 = p_func3;
        end else if (a_issue) begin
            m_wr    = a_we;
            m_rd    = ~a_we;
            m_addr  = a_addr;
            m_wdata = a_wdata;
            m_func3 = a_func3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_own <= 2'b00;
        end else begin
            rd_own <= {p_issue & p_rd & ~p_wr, a_issue & ~a_we};
        end
    end

    assign p_rvalid = reset & rd_own[1];
    assign a_rvalid = reset & rd_own[0];
    assign p_rdata  = p_rvalid ? m_rdata : '0;
    assign a_rdata  = a_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (STARVE_MAX=3); expectations follow
// DMEM_ARB_STARVE_EN when it is defined for the build.
module tb_dmem_arbiter;
    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  p_rd, p_wr;
    logic [DM_ADDRESS-1:0] p_addr;
    logic [DATA_W-1:0]     p_wdata;
    logic [2:0]            p_func3;
    logic                  p_stall, p_rvalid;
    logic [DATA_W-1:0]     p_rdata;
    logic                  a_req, a_we;
    logic [DM_ADDRESS-1:0] a_addr;
    logic [DATA_W-1:0]     a_wdata;
    logic [2:0]            a_func3;
    logic                  a_gnt, a_rvalid;
    logic [DATA_W-1:0]     a_rdata;
    logic                  m_rd, m_wr;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_func3;
    logic [DATA_W-1:0]     m_rdata;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_func3(a_func3),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3),
        .m_rdata(m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_rd"},     32'(m_rd),     32'd0);
        check({tag, " m_wr"},     32'(m_wr),     32'd0);
        check({tag, " m_addr"},   32'(m_addr),   32'd0);
        check({tag, " a_gnt"},    32'(a_gnt),    32'd0);
        check({tag, " p_stall"},  32'(p_stall),  32'd0);
        check({tag, " p_rvalid"}, 32'(p_rvalid), 32'd0);
        check({tag, " a_rvalid"}, 32'(a_rvalid), 32'd0);
        check({tag, " p_rdata"},  32'(p_rdata),  32'd0);
        check({tag, " a_rdata"},  32'(a_rdata),  32'd0);
    endtask

    initial begin
        reset = 1'b0;
        p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0; p_func3 = 3'd0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_func3 = 3'd0;
        m_rdata = 32'h0;

        // Reset held with both ports requesting: every output stays low.
        tick();
        p_rd = 1; p_addr = 9'h010; p_func3 = 3'b010;
        a_req = 1; a_addr = 9'h100; m_rdata = 32'hFFFF_FFFF;
        settle();
        check_all_zero("rst_in");
        tick();
        check_all_zero("rst_hold");

        // Release: P wins the first cycle.
        reset = 1;
        settle();
        check("rel m_rd",    32'(m_rd),    32'd1);
        check("rel m_addr",  32'(m_addr),  32'h010);
        check("rel m_func3", 32'(m_func3), 32'd2);
        check("rel a_gnt",   32'(a_gnt),   32'd0);
        check("rel p_stall", 32'(p_stall), 32'd0);

        // P read data returns one cycle later.
        tick();
        p_rd = 0; a_req = 0; m_rdata = 32'hDEAD_BEEF;
        settle();
        check("prd p_rvalid", 32'(p_rvalid), 32'd1);
        check("prd p_rdata",  p_rdata,       32'hDEAD_BEEF);
        check("prd a_rvalid", 32'(a_rvalid), 32'd0);
        check("prd a_rdata",  a_rdata,       32'd0);
        check("idle m_rd",    32'(m_rd),     32'd0);
        tick();
        m_rdata = 32'h1111_2222;
        settle();
        check("idle p_rvalid", 32'(p_rvalid), 32'd0);
        check("idle p_rdata",  p_rdata,       32'd0);

        // A write while P idle, then A read back.
        a_req = 1; a_we = 1; a_addr = 9'h020; a_wdata = 32'h1234_5678; a_func3 = 3'b010;
        settle();
        check("awr a_gnt",   32'(a_gnt),   32'd1);
        check("awr m_wr",    32'(m_wr),    32'd1);
        check("awr m_rd",    32'(m_rd),    32'd0);
        check("awr m_addr",  32'(m_addr),  32'h020);
        check("awr m_wdata", m_wdata,      32'h1234_5678);
        check("awr m_func3", 32'(m_func3), 32'd2);
        tick();
        a_we = 0;
        settle();
        check("ard a_gnt",    32'(a_gnt),    32'd1);
        check("ard m_rd",     32'(m_rd),     32'd1);
        check("awr a_rvalid", 32'(a_rvalid), 32'd0);
        tick();
        a_req = 0; m_rdata = 32'h1234_5678;
        settle();
        check("ard a_rvalid", 32'(a_rvalid), 32'd1);
        check("ard a_rdata",  a_rdata,       32'h1234_5678);
        check("ard p_rvalid", 32'(p_rvalid), 32'd0);
        check("ard p_rdata",  p_rdata,       32'd0);

        // Back-to-back reads by P then A return in order.
        tick();
        p_rd = 1; p_addr = 9'h030; a_req = 1; a_addr = 9'h040; m_rdata = 32'h0;
        settle();
        check("b2b t a_gnt",  32'(a_gnt),  32'd0);
        check("b2b t m_addr", 32'(m_addr), 32'h030);
        tick();
        p_rd = 0; m_rdata = 32'hAAAA_0001;
        settle();
        check("b2b t1 p_rvalid", 32'(p_rvalid), 32'd1);
        check("b2b t1 p_rdata",  p_rdata,       32'hAAAA_0001);
        check("b2b t1 a_rvalid", 32'(a_rvalid), 32'd0);
        check("b2b t1 a_gnt",    32'(a_gnt),    32'd1);
        check("b2b t1 m_addr",   32'(m_addr),   32'h040);
        tick();
        a_req = 0; m_rdata = 32'hBBBB_0002;
        settle();
        check("b2b t2 a_rvalid", 32'(a_rvalid), 32'd1);
        check("b2b t2 a_rdata",  a_rdata,       32'hBBBB_0002);
        check("b2b t2 p_rvalid", 32'(p_rvalid), 32'd0);

        // P read and write together: write issued, read dropped.
        tick();
        p_rd = 1; p_wr = 1; p_addr = 9'h050; p_wdata = 32'hCAFE_F00D; m_rdata = 32'h55;
        settle();
        check("rw m_wr",    32'(m_wr),   32'd1);
        check("rw m_rd",    32'(m_rd),   32'd0);
        check("rw m_wdata", m_wdata,     32'hCAFE_F00D);
        tick();
        p_rd = 0; p_wr = 0;
        settle();
        check("rw p_rvalid", 32'(p_rvalid), 32'd0);

        // Starvation: P and A both held continuously.
        tick();
        p_rd = 1; p_addr = 9'h070; a_req = 1; a_we = 0; a_addr = 9'h060;
        for (int i = 0; i < 7; i++) begin
            logic fe;
            fe = GUARD && (i == 3);
            settle();
            check($sformatf("stv%0d a_gnt", i),    32'(a_gnt),    32'(fe));
            check($sformatf("stv%0d p_stall", i),  32'(p_stall),  32'(fe));
            check($sformatf("stv%0d m_addr", i),   32'(m_addr),   fe ? 32'h060 : 32'h070);
            check($sformatf("stv%0d p_rvalid", i), 32'(p_rvalid),
                  (i == 0 || (GUARD && i == 4)) ? 32'd0 : 32'd1);
            check($sformatf("stv%0d a_rvalid", i), 32'(a_rvalid), 32'(GUARD && i == 4));
            tick();
        end
        // A drops its request exactly when the forced slot would occur.
        a_req = 0;
        settle();
        check("drop a_gnt",   32'(a_gnt),   32'd0);
        check("drop p_stall", 32'(p_stall), 32'd0);
        check("drop m_rd",    32'(m_rd),    32'd1);
        check("drop m_addr",  32'(m_addr),  32'h070);

        // Counter at 2 when reset hits, right after an issued P read.
        tick();
        a_req = 1;
        tick();
        tick();
        reset = 0; m_rdata = 32'h9999_9999;
        settle();
        check_all_zero("rst2");
        tick();
        reset = 1;
        for (int j = 0; j < 4; j++) begin
            settle();
            if (j == 0) check("rst2 p_rvalid", 32'(p_rvalid), 32'd0);
            check($sformatf("rst2 c%0d a_gnt", j),   32'(a_gnt),   32'(GUARD && j == 3));
            check($sformatf("rst2 c%0d p_stall", j), 32'(p_stall), 32'(GUARD && j == 3));
            tick();
        end
        p_rd = 0; a_req = 0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
